// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, combinational imem read, 2-entry fetch FIFO to decode (1-cycle fetch-to-decode).
// Backpressure: fetch stops while the FIFO is full and not draining; br/jmp redirect the PC and flush the FIFO.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             br,
   input  logic [31:0]      br_target,
   input  logic             jmp,
   input  logic [31:0]      jmp_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic             flush_id,
   output logic             flush_ex,
   output logic [CNT_W-1:0] redirect_cnt
);

   logic [31:0]      pc_q, pc_d;
   logic [31:0]      dat_q [2];
   logic [31:0]      dat_d [2];
   logic [31:0]      epc_q [2];
   logic [31:0]      epc_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             redirect, full, pop, fetch_en;

   assign redirect     = br | jmp;
   assign full         = (occ_q == 2'd2);
   assign inst_valid   = (occ_q != 2'd0);
   assign pop          = inst_valid & inst_ready & ~redirect;
   assign fetch_en     = (~full | pop) & ~redirect;
   assign imem_addr    = pc_q;
   assign inst         = dat_q[rd_ptr_q];
   assign inst_pc      = epc_q[rd_ptr_q];
   assign flush_id     = redirect;
   assign flush_ex     = br;
   assign redirect_cnt = cnt_q;

   always_comb begin
      pc_d     = pc_q;
      dat_d    = dat_q;
      epc_d    = epc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt_d    = cnt_q;

      if (redirect) begin
         // br is the older instruction (EX), so it beats a jump resolved in ID
         pc_d     = br ? {br_target[31:2], 2'b00} : {jmp_target[31:2], 2'b00};
         occ_d    = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (fetch_en) begin
            dat_d[wr_ptr_q] = imem_data;
            epc_d[wr_ptr_q] = pc_q;
            wr_ptr_d        = ~wr_ptr_q;
            pc_d            = pc_q + 32'd4;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         occ_d = occ_q + 2'(fetch_en) - 2'(pop);
      end

      if (redirect && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         dat_q[0] <= '0;
         dat_q[1] <= '0;
         epc_q[0] <= '0;
         epc_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
         cnt_q    <= '0;
      end else begin
         pc_q     <= pc_d;
         dat_q    <= dat_d;
         epc_q    <= epc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined core. It holds the PC, reads instruction memory, and buffers fetched instructions in a 2-entry FIFO. The FIFO hands instructions to decode over a valid/ready handshake. It consumes the taken-branch flag `br` from the EX-stage branch comparator and the jump request from ID. On either redirect it reloads the PC and generates the pipeline flush signals.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `CNT_W`, default 16: width of the redirect counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `br`  in  1  branch taken, from the EX-stage comparator.
- `br_target`  in  32  branch target address.
- `jmp`  in  1  jump resolved in ID (jal/jalr).
- `jmp_target`  in  32  jump target address.
- `imem_addr`  out  32  instruction memory address; memory read is combinational.
- `imem_data`  in  32  instruction word at `imem_addr`, same cycle.
- `inst`  out  32  instruction at the FIFO head.
- `inst_pc`  out  32  PC of `inst`.
- `inst_valid`  out  1  FIFO head is valid.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `flush_id`  out  1  squash the IF/ID register.
- `flush_ex`  out  1  squash the ID/EX register.
- `redirect_cnt`  out  CNT_W  saturating count of redirects.

## Operation
**Reset values**
- pc = RESET_PC, FIFO empty, inst_valid = 0, inst = 0, inst_pc = 0, redirect_cnt = 0.

**Signal definitions**
- `imem_addr = pc`.
- `redirect = br | jmp`.
- `pop = inst_valid & inst_ready & ~redirect`.
- `fetch_en = (~full | pop) & ~redirect`.

**Normal fetch**
- When fetch_en is high, {pc, imem_data} is pushed at the FIFO tail and pc <= pc + 4.
- pc arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

**FIFO**
- Two entries with a 2-bit occupancy (0, 1, 2); `full` = occupancy 2.
- Push and pop in the same cycle leaves occupancy unchanged and keeps order.
- A push while full is possible only together with a pop.

**Redirect**
- Priority: `br` over `jmp`. The branch is older, in EX.
- next pc = {target[31:2], 2'b00}; the low bits are forced to zero.
- The FIFO is cleared, no push occurs, and the decode handshake is ignored that cycle.

**Flush outputs** (combinational)
- flush_id = br | jmp.
- flush_ex = br.

**redirect_cnt**
- Increments on each cycle with redirect = 1.
- Saturates at all ones.

## Timing
- Fetch-to-decode latency is 1 cycle. Fetching address A in cycle N gives inst_valid = 1 with inst_pc = A in cycle N+1.
- After reset deassertion the first fetch is RESET_PC in cycle 0, and inst_valid rises in cycle 1.
- Redirect asserted in cycle N:
  - Cycle N: flush asserted.
  - Cycle N+1: pc = target, inst_valid = 0.
  - Cycle N+2: inst_valid = 1 with inst_pc = target.
- Stall (inst_ready = 0):
  - The FIFO fills within 2 cycles, then pc holds.
  - The head stays stable until accepted.
- Back-to-back redirects in cycles N and N+1: the N+1 target wins, and the FIFO stays empty through N+2.
- Asynchronous reset in mid-operation clears all state immediately, regardless of clk. The flush outputs still follow br/jmp combinationally.

## Test plan
- **Reset and streaming:** RESET_PC = 0x3000, inst_ready = 1, memory holds word = address → inst_pc 0x3000, 0x3004, 0x3008 in cycles 1, 2, 3; inst = inst_pc; no bubbles.
- **Stall:** hold inst_ready = 0 for 5 cycles from cycle 2 → FIFO holds 0x3004 and 0x3008; imem_addr stays at 0x300C; release → 0x3004 then 0x3008 then 0x300C in consecutive cycles.
- **Branch redirect:** br = 1, br_target = 0x3102 in cycle 4 → flush_id = flush_ex = 1 in cycle 4; inst_valid = 0 in cycle 5; inst_pc = 0x3100 in cycle 6; redirect_cnt = 1.
- **Simultaneous br and jmp:** br_target = 0x3200, jmp_target = 0x3400 in the same cycle → next inst_pc 0x3200; flush_ex = 1.
- **Wrap and saturation:** redirect to 0xFFFF_FFF8 → inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. With CNT_W = 2, 5 redirects → redirect_cnt = 3.
- **Reset mid-stall:** assert rst asynchronously with a full FIFO → inst_valid = 0 and pc = RESET_PC before the next clk edge.
